// File: rtl/conf_int_mul_result_checker.sv
// conf_int_mul_result_checker
//   Consumes (a, b, d) triples from the signed-multiplier wrapper, recomputes the
//   golden signed product with a shift-add engine (one multiplier bit per cycle)
//   and compares it to d. Exact or tolerance compare is selected per triple.
//   Keeps saturating check/mismatch counters and latches the first failing triple.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        triple handshake (in_ready = !busy)
//   a, b, d, acc__sel          operands, DUT product, 1=exact / 0=tolerance compare
//   busy                       high while multiplying or comparing
//   res_valid, res_match       one-cycle result pulse and its match bit
//   checked_cnt, mismatch_cnt  saturating counters
//   err_flag                   sticky mismatch flag
//   first_err_a/b/d/exp        triple and golden product of the first mismatch
module conf_int_mul_result_checker #(
    parameter int OP_BITWIDTH = 32,
    parameter int CNT_W       = 16,
    parameter int ERR_TOL     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_BITWIDTH-1:0]     a,
    input  logic [OP_BITWIDTH-1:0]     b,
    input  logic [2*OP_BITWIDTH-1:0]   d,
    input  logic                       acc__sel,
    output logic                       busy,
    output logic                       res_valid,
    output logic                       res_match,
    output logic [CNT_W-1:0]           checked_cnt,
    output logic [CNT_W-1:0]           mismatch_cnt,
    output logic                       err_flag,
    output logic [OP_BITWIDTH-1:0]     first_err_a,
    output logic [OP_BITWIDTH-1:0]     first_err_b,
    output logic [2*OP_BITWIDTH-1:0]   first_err_d,
    output logic [2*OP_BITWIDTH-1:0]   first_err_exp
);

    localparam int PW     = 2 * OP_BITWIDTH;
    localparam int STEP_W = (OP_BITWIDTH > 1) ? $clog2(OP_BITWIDTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OP_BITWIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CMP
    } state_e;

    state_e                   state_q, state_d;
    logic [OP_BITWIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [PW-1:0]            d_q, d_d;
    logic                     sel_q, sel_d;
    logic                     sign_q, sign_d;
    logic [PW-1:0]            mcand_q, mcand_d;   // |a|, shifted left each step
    logic [OP_BITWIDTH-1:0]   mplier_q, mplier_d; // |b|, shifted right each step
    logic [PW-1:0]            acc_q, acc_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     res_valid_q, res_valid_d;
    logic                     res_match_q, res_match_d;
    logic [CNT_W-1:0]         checked_q, checked_d;
    logic [CNT_W-1:0]         mismatch_q, mismatch_d;
    logic                     err_q, err_d;
    logic [OP_BITWIDTH-1:0]   fe_a_q, fe_a_d, fe_b_q, fe_b_d;
    logic [PW-1:0]            fe_d_q, fe_d_d, fe_exp_q, fe_exp_d;

    logic [PW-1:0]            golden;
    logic [PW:0]              diff;
    logic [PW:0]              abs_diff;
    logic                     match;
    logic [OP_BITWIDTH-1:0]   mag_a, mag_b;

    // Magnitudes of the most negative operand come out correct as unsigned values.
    assign mag_a = a[OP_BITWIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[OP_BITWIDTH-1] ? (~b + 1'b1) : b;

    // Difference is one bit wider than the product so it cannot overflow.
    assign golden   = sign_q ? (PW'(0) - acc_q) : acc_q;
    assign diff     = {d_q[PW-1], d_q} - {golden[PW-1], golden};
    assign abs_diff = diff[PW] ? ((PW+1)'(0) - diff) : diff;
    assign match    = sel_q ? (d_q == golden) : (abs_diff <= (PW+1)'(ERR_TOL));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        sel_d       = sel_q;
        sign_d      = sign_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        step_d      = step_q;
        res_valid_d = 1'b0;
        res_match_d = res_match_q;
        checked_d   = checked_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        fe_a_d      = fe_a_q;
        fe_b_d      = fe_b_q;
        fe_d_d      = fe_d_q;
        fe_exp_d    = fe_exp_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    d_d      = d;
                    sel_d    = acc__sel;
                    sign_d   = a[OP_BITWIDTH-1] ^ b[OP_BITWIDTH-1];
                    mcand_d  = PW'(mag_a);
                    mplier_d = mag_b;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                res_valid_d = 1'b1;
                res_match_d = match;
                if (checked_q != '1) begin
                    checked_d = checked_q + CNT_W'(1);
                end
                if (!match) begin
                    if (mismatch_q != '1) begin
                        mismatch_d = mismatch_q + CNT_W'(1);
                    end
                    err_d = 1'b1;
                    if (!err_q) begin
                        fe_a_d   = a_q;
                        fe_b_d   = b_q;
                        fe_d_d   = d_q;
                        fe_exp_d = golden;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            sel_q       <= 1'b0;
            sign_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            checked_q   <= '0;
            mismatch_q  <= '0;
            err_q       <= 1'b0;
            fe_a_q      <= '0;
            fe_b_q      <= '0;
            fe_d_q      <= '0;
            fe_exp_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            sel_q       <= sel_d;
            sign_q      <= sign_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            checked_q   <= checked_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            fe_a_q      <= fe_a_d;
            fe_b_q      <= fe_b_d;
            fe_d_q      <= fe_d_d;
            fe_exp_q    <= fe_exp_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign in_ready      = !busy;
    assign res_valid     = res_valid_q;
    assign res_match     = res_match_q;
    assign checked_cnt   = checked_q;
    assign mismatch_cnt  = mismatch_q;
    assign err_flag      = err_q;
    assign first_err_a   = fe_a_q;
    assign first_err_b   = fe_b_q;
    assign first_err_d   = fe_d_q;
    assign first_err_exp = fe_exp_q;

endmodule

// File: tb/tb_conf_int_mul_result_checker.sv
// Testbench for conf_int_mul_result_checker. Two instances share one stimulus
// stream: default parameters, and a narrow-counter / ERR_TOL=4 variant.
module tb_conf_int_mul_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] d = '0;
    logic        acc__sel = 1'b0;

    logic        in_ready0, busy0, res_valid0, res_match0, err_flag0;
    logic [15:0] checked_cnt0, mismatch_cnt0;
    logic [31:0] fe_a0, fe_b0;
    logic [63:0] fe_d0, fe_exp0;

    logic        in_ready1, busy1, res_valid1, res_match1, err_flag1;
    logic [3:0]  checked_cnt1, mismatch_cnt1;
    logic [31:0] fe_a1, fe_b1;
    logic [63:0] fe_d1, fe_exp1;

    int checks = 0;
    int failures = 0;

    // reference model state, index 0 = default instance, 1 = narrow/tolerant instance
    int          m_max [2] = '{65535, 15};
    int          m_tol [2] = '{0, 4};
    int          m_chk [2];
    int          m_mis [2];
    bit          m_err [2];
    bit          m_match [2];
    logic [31:0] m_fa [2];
    logic [31:0] m_fb [2];
    logic [63:0] m_fd [2];
    logic [63:0] m_fe [2];

    int rv0 = 0, rv1 = 0, rv_exp = 0;
    int acc0 = 0, acc1 = 0, n_accept = 0;
    logic b0p = 1'b0, b1p = 1'b0;

    always #5 clk = ~clk;

    conf_int_mul_result_checker #(.OP_BITWIDTH(32), .CNT_W(16), .ERR_TOL(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .d(d), .acc__sel(acc__sel),
        .busy(busy0), .res_valid(res_valid0), .res_match(res_match0),
        .checked_cnt(checked_cnt0), .mismatch_cnt(mismatch_cnt0), .err_flag(err_flag0),
        .first_err_a(fe_a0), .first_err_b(fe_b0), .first_err_d(fe_d0), .first_err_exp(fe_exp0)
    );

    conf_int_mul_result_checker #(.OP_BITWIDTH(32), .CNT_W(4), .ERR_TOL(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .d(d), .acc__sel(acc__sel),
        .busy(busy1), .res_valid(res_valid1), .res_match(res_match1),
        .checked_cnt(checked_cnt1), .mismatch_cnt(mismatch_cnt1), .err_flag(err_flag1),
        .first_err_a(fe_a1), .first_err_b(fe_b1), .first_err_d(fe_d1), .first_err_exp(fe_exp1)
    );

    // result pulses and accepted triples (busy rising) seen by each instance
    always @(negedge clk) begin
        if (res_valid0 === 1'b1) rv0++;
        if (res_valid1 === 1'b1) rv1++;
        if (busy0 === 1'b1 && b0p === 1'b0) acc0++;
        if (busy1 === 1'b1 && b1p === 1'b0) acc1++;
        b0p = busy0;
        b1p = busy1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    function automatic bit model_match(input logic [63:0] dv, input logic [63:0] g,
                                       input bit sel, input int tol);
        logic signed [64:0] df;
        if (sel) return dv == g;
        df = $signed({dv[63], dv}) - $signed({g[63], g});
        if (df < 0) df = -df;
        return df <= tol;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_chk[i] = 0; m_mis[i] = 0; m_err[i] = 0; m_match[i] = 0;
            m_fa[i] = '0; m_fb[i] = '0; m_fd[i] = '0; m_fe[i] = '0;
        end
    endtask

    task automatic model_apply(input logic [31:0] av, input logic [31:0] bv,
                               input logic [63:0] dv, input bit sv);
        logic [63:0] g;
        g = golden(av, bv);
        for (int i = 0; i < 2; i++) begin
            m_match[i] = model_match(dv, g, sv, m_tol[i]);
            if (m_chk[i] < m_max[i]) m_chk[i]++;
            if (!m_match[i]) begin
                if (m_mis[i] < m_max[i]) m_mis[i]++;
                if (!m_err[i]) begin
                    m_fa[i] = av; m_fb[i] = bv; m_fd[i] = dv; m_fe[i] = g;
                end
                m_err[i] = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/checked0"},  checked_cnt0,  m_chk[0]);
        chk({tag, "/mismatch0"}, mismatch_cnt0, m_mis[0]);
        chk({tag, "/err0"},      err_flag0,     m_err[0]);
        chk({tag, "/fe_a0"},     fe_a0,         m_fa[0]);
        chk({tag, "/fe_b0"},     fe_b0,         m_fb[0]);
        chk({tag, "/fe_d0"},     fe_d0,         m_fd[0]);
        chk({tag, "/fe_exp0"},   fe_exp0,       m_fe[0]);
        chk({tag, "/checked1"},  checked_cnt1,  m_chk[1]);
        chk({tag, "/mismatch1"}, mismatch_cnt1, m_mis[1]);
        chk({tag, "/err1"},      err_flag1,     m_err[1]);
        chk({tag, "/fe_a1"},     fe_a1,         m_fa[1]);
        chk({tag, "/fe_b1"},     fe_b1,         m_fb[1]);
        chk({tag, "/fe_d1"},     fe_d1,         m_fd[1]);
        chk({tag, "/fe_exp1"},   fe_exp1,       m_fe[1]);
    endtask

    // Called at a negedge with both instances idle; returns at a negedge, idle.
    // Inputs are scrambled and in_valid kept high for most of the busy window.
    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] dv, input bit sv, input string tag);
        int lat;
        chk({tag, "/in_ready0"}, in_ready0, 1);
        chk({tag, "/in_ready1"}, in_ready1, 1);
        a = av; b = bv; d = dv; acc__sel = sv; in_valid = 1'b1;
        n_accept++;
        lat = -1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat < 20) begin
                a = $urandom; b = $urandom; d = {$urandom, $urandom};
                acc__sel = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end while (res_valid0 !== 1'b1 && lat < 100);
        in_valid = 1'b0;
        model_apply(av, bv, dv, sv);
        rv_exp++;
        chk({tag, "/latency"},    lat,        33);
        chk({tag, "/res_valid1"}, res_valid1, 1);
        chk({tag, "/match0"},     res_match0, m_match[0]);
        chk({tag, "/match1"},     res_match1, m_match[1]);
        check_state(tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/pulse_end"}, res_valid0, 0);
    endtask

    function automatic logic [31:0] pick_op();
        logic [31:0] t [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return t[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($signed(16'($urandom)));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] g, rd;
        int delta;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst/busy0", busy0, 0);
        chk("rst/busy1", busy1, 0);
        chk("rst/res_valid0", res_valid0, 0);
        chk("rst/res_match0", res_match0, 0);
        check_state("rst");

        // T1
        send(32'd3, -32'sd5, -64'sd15, 1'b1, "T1");
        chk("T1/match_const", res_match0, 1);

        // T5: reset in the middle of the multiply
        a = 32'd9; b = 32'd9; d = 64'd80; acc__sel = 1'b1; in_valid = 1'b1;
        n_accept++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("T5/in_ready0", in_ready0, 1);
        chk("T5/in_ready1", in_ready1, 1);
        chk("T5/busy0", busy0, 0);
        chk("T5/res_valid0", res_valid0, 0);
        check_state("T5");
        repeat (40) @(negedge clk);
        chk("T5/no_pulse0", rv0, rv_exp);
        chk("T5/no_pulse1", rv1, rv_exp);
        send(32'd3, -32'sd5, -64'sd15, 1'b1, "T5b");

        // T2
        send(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, "T2a");
        chk("T2a/match_const", res_match0, 1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b1, "T2b");
        chk("T2b/match_const", res_match0, 1);

        // T3
        send(32'd7, 32'd6, 64'd41, 1'b1, "T3a");
        send(32'd2, 32'd2, 64'd5, 1'b1, "T3b");
        chk("T3/mismatch_const", mismatch_cnt0, 2);
        chk("T3/fe_exp_const", fe_exp0, 64'd42);
        chk("T3/fe_d_const", fe_d0, 64'd41);

        // T4: tolerance compare (instance 1 has ERR_TOL=4)
        send(32'd10, 32'd10, 64'd104, 1'b0, "T4a");
        chk("T4a/match1_const", res_match1, 1);
        send(32'd10, 32'd10, 64'd95, 1'b0, "T4b");
        chk("T4b/match1_const", res_match1, 0);
        send(32'd10, 32'd10, 64'd104, 1'b1, "T4c");
        chk("T4c/match1_const", res_match1, 0);

        // random triples: exact, near-miss and arbitrary products
        for (int i = 0; i < 50; i++) begin
            ra = pick_op();
            rb = pick_op();
            g = golden(ra, rb);
            delta = int'($urandom_range(0, 12)) - 6;
            case ($urandom_range(0, 2))
                0: rd = g;
                1: rd = g + longint'(delta);
                default: rd = {$urandom, $urandom};
            endcase
            send(ra, rb, rd, 1'($urandom), "RND");
        end

        // T6: many mismatches drive the narrow counters into saturation
        for (int i = 0; i < 20; i++) begin
            ra = pick_op();
            rb = pick_op();
            send(ra, rb, golden(ra, rb) + 64'd100, 1'($urandom), "T6");
        end
        chk("T6/sat_checked1", checked_cnt1, 15);
        chk("T6/sat_mismatch1", mismatch_cnt1, 15);

        repeat (5) @(negedge clk);
        chk("end/pulses0", rv0, rv_exp);
        chk("end/pulses1", rv1, rv_exp);
        chk("end/accepts0", acc0, n_accept);
        chk("end/accepts1", acc1, n_accept);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
